// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports and the single-port RAM side of ram_arbiter.
// slave is the arbiter's view; master is the requesters/RAM environment view.
interface ram_arbiter_if #(
    parameter int RAM_WIDTH     = 16,
    parameter int RAM_ADDR_BITS = 12
);
    logic                     a_req;
    logic                     a_we;
    logic [RAM_ADDR_BITS-1:0] a_addr;
    logic [RAM_WIDTH-1:0]     a_wdata;
    logic                     a_gnt;
    logic                     a_rvalid;
    logic [RAM_WIDTH-1:0]     a_rdata;

    logic                     b_req;
    logic                     b_we;
    logic [RAM_ADDR_BITS-1:0] b_addr;
    logic [RAM_WIDTH-1:0]     b_wdata;
    logic                     b_lock;
    logic                     b_gnt;
    logic                     b_rvalid;
    logic [RAM_WIDTH-1:0]     b_rdata;

    logic                     ram_en;
    logic                     ram_wr_en;
    logic [RAM_ADDR_BITS-1:0] ram_addr;
    logic [RAM_WIDTH-1:0]     ram_din;
    logic [RAM_WIDTH-1:0]     ram_dout;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata, b_lock,
        output b_gnt, b_rvalid, b_rdata,
        output ram_en, ram_wr_en, ram_addr, ram_din,
        input  ram_dout
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata, b_lock,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_en, ram_wr_en, ram_addr, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one single-port block RAM between port A (CPU) and port B (DMA/display),
// with round-robin contention and a bounded burst lock for port B.
module ram_arbiter #(
    parameter int RAM_WIDTH     = 16,
    parameter int RAM_ADDR_BITS = 12,
    parameter int LOCK_MAX      = 8
) (
    input logic          clk,
    input logic          reset,
    ram_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic {ARB, LOCK_B} mode_t;

    mode_t            mode;
    mode_t            mode_next;
    logic             last;
    logic             last_next;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             rd_a;
    logic             rd_b;
    logic             gnt_a;
    logic             gnt_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            mode     <= ARB;
            last     <= PORT_B;
            lock_cnt <= '0;
            rd_a     <= 1'b0;
            rd_b     <= 1'b0;
        end else begin
            mode     <= mode_next;
            last     <= last_next;
            lock_cnt <= lock_cnt_next;
            rd_a     <= gnt_a & ~bus.a_we;
            rd_b     <= gnt_b & ~bus.b_we;
        end
    end

    assign cnt_inc = lock_cnt + CNT_W'(1);

    always_comb begin
        gnt_a         = 1'b0;
        gnt_b         = 1'b0;
        mode_next     = mode;
        last_next     = last;
        lock_cnt_next = lock_cnt;
        if (!reset) begin
            case (mode)
                ARB: begin
                    if (bus.a_req && bus.b_req) begin
                        gnt_a = (last == PORT_B);
                        gnt_b = (last == PORT_A);
                    end else begin
                        gnt_a = bus.a_req;
                        gnt_b = bus.b_req;
                    end
                    if (gnt_a) last_next = PORT_A;
                    if (gnt_b) begin
                        last_next = PORT_B;
                        if (bus.b_lock && (LOCK_MAX > 1)) begin
                            mode_next     = LOCK_B;
                            lock_cnt_next = CNT_W'(1);
                        end
                    end
                end
                LOCK_B: begin
                    // B owns the RAM; A only fills cycles B leaves empty
                    gnt_b = bus.b_req;
                    gnt_a = bus.a_req && !bus.b_req;
                    if (gnt_b) lock_cnt_next = cnt_inc;
                    if ((gnt_b && (!bus.b_lock || (cnt_inc == CNT_W'(LOCK_MAX)))) ||
                        (!bus.b_req && !bus.b_lock)) begin
                        mode_next     = ARB;
                        last_next     = PORT_B;
                        lock_cnt_next = '0;
                    end
                end
                default: mode_next = ARB;
            endcase
        end
    end

    assign bus.a_gnt     = gnt_a;
    assign bus.b_gnt     = gnt_b;
    assign bus.ram_en    = gnt_a | gnt_b;
    assign bus.ram_wr_en = (gnt_a & bus.a_we) | (gnt_b & bus.b_we);
    assign bus.ram_addr  = gnt_b ? bus.b_addr : bus.a_addr;
    assign bus.ram_din   = gnt_b ? bus.b_wdata : bus.a_wdata;

    assign bus.a_rvalid = rd_a;
    assign bus.b_rvalid = rd_b;
    assign bus.a_rdata  = bus.ram_dout;
    assign bus.b_rdata  = bus.ram_dout;
endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter: a rule-level arbitration model predicts grants,
// and a scoreboard queue of expected read returns is drained by a separate monitor.
module tb_ram_arbiter;
    localparam int W  = 16;
    localparam int AW = 12;
    localparam int LM = 8;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_arbiter_if #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AW)) ifc ();

    ram_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AW), .LOCK_MAX(LM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    function automatic logic [W-1:0] init_val(input int i);
        return W'(i * 40503 + 23130);
    endfunction

    // Behavioural single-port RAM with registered read data
    logic [W-1:0] ram_mem [0:63];
    bit           ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 64; i++) ram_mem[i] = init_val(i);
            ram_init = 1'b1;
        end
        if (ifc.ram_en) begin
            if (ifc.ram_wr_en) ram_mem[ifc.ram_addr[5:0]] = ifc.ram_din;
            else ifc.ram_dout <= ram_mem[ifc.ram_addr[5:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit           port;
        logic [W-1:0] data;
        int           cyc;
    } rd_t;
    rd_t q[$];

    // Reference model: mode as a flag, plus last winner and lock length
    bit           m_locked = 1'b0;
    bit           m_last   = 1'b1;
    int           m_cnt    = 0;
    logic [W-1:0] shadow [0:63];
    bit           sh_init  = 1'b0;
    bit           exp_a, exp_b;

    always @(negedge clk) begin
        if (!sh_init) begin
            for (int i = 0; i < 64; i++) shadow[i] = init_val(i);
            sh_init = 1'b1;
        end
        if (reset) begin
            exp_a = 1'b0;
            exp_b = 1'b0;
        end else if (m_locked) begin
            exp_b = ifc.b_req;
            exp_a = ifc.a_req && !ifc.b_req;
        end else if (ifc.a_req && ifc.b_req) begin
            exp_a = m_last;
            exp_b = !m_last;
        end else begin
            exp_a = ifc.a_req;
            exp_b = ifc.b_req;
        end
        chk("a_gnt", 32'(ifc.a_gnt), 32'(exp_a));
        chk("b_gnt", 32'(ifc.b_gnt), 32'(exp_b));
        chk("ram_en", 32'(ifc.ram_en), 32'(exp_a | exp_b));
        chk("ram_wr_en", 32'(ifc.ram_wr_en), 32'((exp_a & ifc.a_we) | (exp_b & ifc.b_we)));
        chk("ram_addr", 32'(ifc.ram_addr), exp_b ? 32'(ifc.b_addr) : 32'(ifc.a_addr));
        if (exp_a && ifc.a_we) chk("ram_din", 32'(ifc.ram_din), 32'(ifc.a_wdata));
        if (exp_b && ifc.b_we) chk("ram_din", 32'(ifc.ram_din), 32'(ifc.b_wdata));

        if (exp_a) begin
            if (ifc.a_we) shadow[ifc.a_addr[5:0]] = ifc.a_wdata;
            else q.push_back('{1'b0, shadow[ifc.a_addr[5:0]], cyc});
        end
        if (exp_b) begin
            if (ifc.b_we) shadow[ifc.b_addr[5:0]] = ifc.b_wdata;
            else q.push_back('{1'b1, shadow[ifc.b_addr[5:0]], cyc});
        end

        if (reset) begin
            m_locked = 1'b0;
            m_last   = 1'b1;
            m_cnt    = 0;
        end else if (!m_locked) begin
            if (exp_a) m_last = 1'b0;
            if (exp_b) begin
                m_last = 1'b1;
                if (ifc.b_lock && LM > 1) begin
                    m_locked = 1'b1;
                    m_cnt    = 1;
                end
            end
        end else begin
            if (exp_b) begin
                m_cnt++;
                if (!ifc.b_lock || m_cnt == LM) begin
                    m_locked = 1'b0;
                    m_cnt    = 0;
                end
            end else if (!ifc.b_req && !ifc.b_lock) begin
                m_locked = 1'b0;
                m_cnt    = 0;
            end
            m_last = 1'b1;
        end
    end

    // Monitor: each rvalid must match the oldest expected read, granted one cycle earlier
    rd_t item;
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            if (ifc.a_rvalid && ifc.b_rvalid) chk("single_rvalid", 32'd1, 32'd0);
            if (ifc.a_rvalid || ifc.b_rvalid) begin
                if (q.size() == 0 || q[0].cyc != cyc - 1) begin
                    chk("unexpected_rvalid", {30'd0, ifc.b_rvalid, ifc.a_rvalid}, 32'd0);
                end else begin
                    item = q.pop_front();
                    chk("rvalid_port", {30'd0, ifc.b_rvalid, ifc.a_rvalid}, item.port ? 32'd2 : 32'd1);
                    chk("rdata", item.port ? 32'(ifc.b_rdata) : 32'(ifc.a_rdata), 32'(item.data));
                end
            end else if (q.size() != 0 && q[0].cyc < cyc) begin
                item = q.pop_front();
                chk("missing_rvalid", 32'd0, item.port ? 32'd2 : 32'd1);
            end
        end
    end

    bit a_pend = 1'b0;
    bit b_pend = 1'b0;

    task automatic cycle(input int pa, input int pb, input int plock, input int pwr, input bit rst = 1'b0);
        @(posedge clk);
        #1;
        reset = rst;
        if (!a_pend && ($urandom_range(99) < pa)) begin
            a_pend      = 1'b1;
            ifc.a_we    = ($urandom_range(99) < pwr);
            ifc.a_addr  = AW'($urandom_range(63));
            ifc.a_wdata = W'($urandom);
        end
        if (!b_pend && ($urandom_range(99) < pb)) begin
            b_pend      = 1'b1;
            ifc.b_we    = ($urandom_range(99) < pwr);
            ifc.b_addr  = AW'($urandom_range(63));
            ifc.b_wdata = W'($urandom);
        end
        ifc.a_req  = a_pend;
        ifc.b_req  = b_pend;
        ifc.b_lock = ($urandom_range(99) < plock);
        @(negedge clk);
        #1;
        if (ifc.a_gnt) a_pend = 1'b0;
        if (ifc.b_gnt) b_pend = 1'b0;
    endtask

    task automatic drain();
        repeat (6) cycle(0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        ifc.a_req = 1'b0; ifc.a_we = 1'b0; ifc.a_addr = '0; ifc.a_wdata = '0;
        ifc.b_req = 1'b0; ifc.b_we = 1'b0; ifc.b_addr = '0; ifc.b_wdata = '0;
        ifc.b_lock = 1'b0;
        repeat (3) cycle(0, 0, 0, 0, 1'b1);

        a_pend = 1'b1; ifc.a_we = 1'b0; ifc.a_addr = 12'h010;
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);

        a_pend = 1'b1; ifc.a_we = 1'b0; ifc.a_addr = 12'h011;
        b_pend = 1'b1; ifc.b_we = 1'b0; ifc.b_addr = 12'h012;
        repeat (6) cycle(100, 100, 0, 0);
        drain();

        b_pend = 1'b1; ifc.b_we = 1'b1; ifc.b_addr = 12'h020; ifc.b_wdata = 16'h1234;
        cycle(0, 0, 0, 0);
        a_pend = 1'b1; ifc.a_we = 1'b0; ifc.a_addr = 12'h020;
        cycle(0, 0, 0, 0);
        drain();

        repeat (30) cycle(100, 100, 100, 0);
        repeat (80) cycle(100, 80, 95, 30);
        drain();

        a_pend = 1'b1; ifc.a_we = 1'b0; ifc.a_addr = 12'h005;
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1'b1);
        a_pend = 1'b1; ifc.a_we = 1'b0; ifc.a_addr = 12'h006;
        b_pend = 1'b1; ifc.b_we = 1'b0; ifc.b_addr = 12'h007;
        cycle(0, 0, 0, 0);
        drain();

        for (int blk = 0; blk < 30; blk++) begin
            int pa, pb, pl, pw;
            pa = $urandom_range(100);
            pb = $urandom_range(100);
            pl = $urandom_range(100);
            pw = $urandom_range(60);
            repeat (100) cycle(pa, pb, pl, pw, ($urandom_range(199) == 0));
        end
        drain();

        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
